// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: command codes, payload lengths
// and reset colours.
package spi_reg_bank_pkg;

  localparam int MAX_PAYLOAD = 12;
  localparam int CMD_BITS    = 4;

  localparam logic [3:0] CMD_SKY    = 4'd0;
  localparam logic [3:0] CMD_FLOOR  = 4'd1;
  localparam logic [3:0] CMD_LEAK   = 4'd2;
  localparam logic [3:0] CMD_OTHER  = 4'd3;
  localparam logic [3:0] CMD_VSHIFT = 4'd4;
  localparam logic [3:0] CMD_VINF   = 4'd5;

  localparam logic [5:0] SKY_DEFAULT   = 6'b010101;
  localparam logic [5:0] FLOOR_DEFAULT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_IGNORE
  } rx_state_e;

  // A zero length marks the command as invalid.
  function automatic logic [3:0] payload_len(input logic [3:0] cmd);
    case (cmd)
      CMD_SKY, CMD_FLOOR, CMD_LEAK, CMD_VSHIFT: return 4'd6;
      CMD_OTHER:                                return 4'd12;
      CMD_VINF:                                 return 4'd1;
      default:                                  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// N-stage synchroniser for one asynchronous SPI pin, with rise/fall detection
// against a history flop.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-written control register bank for rbzero; writes are staged and only
// reach the outputs on the frame-boundary load strobe.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] SKY_RESET   = SKY_DEFAULT,
  parameter logic [5:0] FLOOR_RESET = FLOOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_reg_csb,
  input  logic       i_reg_sclk,
  input  logic       i_reg_mosi,
  input  logic       i_load_new,
  output logic [5:0] o_sky,
  output logic [5:0] o_floor,
  output logic [5:0] o_leak,
  output logic [5:0] o_otherx,
  output logic [5:0] o_othery,
  output logic [5:0] o_vshift,
  output logic       o_vinf,
  output logic       o_cmd_done,
  output logic       o_busy
);

  logic w_csb, w_csb_rise, w_csb_fall;
  logic w_sclk_rise, w_sclk_sync_unused, w_sclk_fall_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .reset(reset), .i_async(i_reg_csb),
    .o_sync(w_csb), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_async(i_reg_sclk),
    .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_async(i_reg_mosi),
    .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  rx_state_e              r_state;
  logic [3:0]             r_cnt;
  logic [3:0]             r_len;
  logic [3:0]             r_cmd;
  logic [MAX_PAYLOAD-1:0] r_shift;
  logic [MAX_PAYLOAD-1:0] r_commit_data;
  logic [MAX_PAYLOAD-1:0] w_shift_next;

  assign w_shift_next = {r_shift[MAX_PAYLOAD-2:0], w_mosi};
  assign o_busy       = ~w_csb;

  // Receive FSM. A finished payload is held in r_commit_data and committed to
  // staging one clk later, the same clk o_cmd_done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_len         <= '0;
      r_cmd         <= '0;
      r_shift       <= '0;
      r_commit_data <= '0;
      o_cmd_done    <= 1'b0;
    end else begin
      o_cmd_done <= 1'b0;
      if (w_csb_rise) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_csb_fall) begin
              r_state <= ST_CMD;
              r_shift <= '0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_next;
              if (r_cnt == 4'(CMD_BITS - 1)) begin
                r_cnt   <= '0;
                r_cmd   <= w_shift_next[3:0];
                r_len   <= payload_len(w_shift_next[3:0]);
                r_state <= (payload_len(w_shift_next[3:0]) != 4'd0) ? ST_DATA : ST_IGNORE;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_next;
              if (r_cnt == r_len - 4'd1) begin
                r_cnt         <= '0;
                r_commit_data <= w_shift_next;
                o_cmd_done    <= 1'b1;
                r_state       <= ST_IGNORE;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_IGNORE: begin
            r_cnt <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [5:0] r_buf_sky, r_buf_floor, r_buf_leak, r_buf_otherx, r_buf_othery, r_buf_vshift;
  logic       r_buf_vinf;
  logic [5:0] r_pending;

  // Apply uses the pending flags as they stood before this clk's commit, so a
  // write committing alongside i_load_new waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_sky        <= SKY_RESET;
      o_floor      <= FLOOR_RESET;
      o_leak       <= '0;
      o_otherx     <= '0;
      o_othery     <= '0;
      o_vshift     <= '0;
      o_vinf       <= 1'b0;
      r_buf_sky    <= '0;
      r_buf_floor  <= '0;
      r_buf_leak   <= '0;
      r_buf_otherx <= '0;
      r_buf_othery <= '0;
      r_buf_vshift <= '0;
      r_buf_vinf   <= 1'b0;
      r_pending    <= '0;
    end else begin
      if (i_load_new) begin
        if (r_pending[0]) o_sky   <= r_buf_sky;
        if (r_pending[1]) o_floor <= r_buf_floor;
        if (r_pending[2]) o_leak  <= r_buf_leak;
        if (r_pending[3]) begin
          o_otherx <= r_buf_otherx;
          o_othery <= r_buf_othery;
        end
        if (r_pending[4]) o_vshift <= r_buf_vshift;
        if (r_pending[5]) o_vinf   <= r_buf_vinf;
        r_pending <= '0;
      end
      if (o_cmd_done) begin
        case (r_cmd)
          CMD_SKY: begin
            r_buf_sky    <= r_commit_data[5:0];
            r_pending[0] <= 1'b1;
          end
          CMD_FLOOR: begin
            r_buf_floor  <= r_commit_data[5:0];
            r_pending[1] <= 1'b1;
          end
          CMD_LEAK: begin
            r_buf_leak   <= r_commit_data[5:0];
            r_pending[2] <= 1'b1;
          end
          CMD_OTHER: begin
            r_buf_otherx <= r_commit_data[11:6];
            r_buf_othery <= r_commit_data[5:0];
            r_pending[3] <= 1'b1;
          end
          CMD_VSHIFT: begin
            r_buf_vshift <= r_commit_data[5:0];
            r_pending[4] <= 1'b1;
          end
          CMD_VINF: begin
            r_buf_vinf   <= r_commit_data[0];
            r_pending[5] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
